// File: rtl/message_pkg.sv
// message_pkg: shared header-field offsets and arbiter state encoding
package message_pkg;
   localparam int HDR_TOP_OFS = 1;
   localparam int LEN_TOP_OFS = 2;
   typedef enum logic {IDLE, PASS} state_t;
endpackage

// File: rtl/message_rr_select.sv
// message_rr_select: first requesting index at or above ptr, wrapping around
module message_rr_select #(
   parameter int N     = 4,
   parameter int LOG_N = 2
) (
   input  logic [N-1:0]     req,
   input  logic [LOG_N-1:0] ptr,
   output logic [LOG_N-1:0] grant,
   output logic             any_valid
);
   // Scan farthest-first so the closest requester to ptr wins last
   always_comb begin
      grant = '0;
      for (int i = N - 1; i >= 0; i--)
         if (req[(int'(ptr) + i) % N]) grant = LOG_N'((int'(ptr) + i) % N);
   end
   assign any_valid = |req;
endmodule

// File: rtl/message_packet_arbiter.sv
// message_packet_arbiter: round-robin packet-atomic merge of message streams
module message_packet_arbiter
   import message_pkg::*;
#(
   parameter int N_STREAMS             = 4,
   parameter int LOG_N_STREAMS         = 2,
   parameter int WIDTH                 = 32,
   parameter int LOG_MAX_PACKET_LENGTH = 10
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [WIDTH*N_STREAMS-1:0] in_data,
   input  logic [N_STREAMS-1:0]       in_valid,
   output logic [N_STREAMS-1:0]       in_ready,
   output logic [WIDTH-1:0]           out_data,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [LOG_N_STREAMS-1:0]   cur_stream,
   output logic                       busy,
   output logic                       error
);
   state_t                           state;
   logic [LOG_N_STREAMS-1:0]         rr_ptr, grant, sel;
   logic [LOG_MAX_PACKET_LENGTH-1:0] remaining, len;
   logic [WIDTH-1:0]                 word;
   logic                             any_valid, can_load, fire, hdr, load;

   function automatic logic [LOG_N_STREAMS-1:0] next_idx(input logic [LOG_N_STREAMS-1:0] i);
      return i == LOG_N_STREAMS'(N_STREAMS - 1) ? '0 : i + 1'b1;
   endfunction

   message_rr_select #(.N(N_STREAMS), .LOG_N(LOG_N_STREAMS)) u_rr (
      .req(in_valid), .ptr(rr_ptr), .grant(grant), .any_valid(any_valid)
   );

   assign can_load = !out_valid || out_ready;
   assign sel      = state == PASS ? cur_stream : grant;
   assign word     = in_data[sel*WIDTH +: WIDTH];
   assign hdr      = word[WIDTH-HDR_TOP_OFS];
   assign len      = word[WIDTH-LEN_TOP_OFS -: LOG_MAX_PACKET_LENGTH];
   assign busy     = state == PASS;
   assign fire     = in_valid[sel] && in_ready[sel];
   assign load     = fire && (state == PASS || hdr);

   // One-hot ready to the owner in PASS, or to the round-robin winner in IDLE
   always_comb begin
      in_ready = '0;
      if (!rst && can_load && (state == PASS || any_valid)) in_ready[sel] = 1'b1;
   end

   // Packet ownership, round-robin pointer and the registered output word
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         rr_ptr     <= '0;
         remaining  <= '0;
         cur_stream <= '0;
         out_valid  <= 1'b0;
         out_data   <= '0;
         error      <= 1'b0;
      end else begin
         if (can_load) out_valid <= load;
         if (load) out_data <= word;
         if (fire && state == IDLE) begin
            cur_stream <= grant;
            if (!hdr) error <= 1'b1;
            else if (len == '0) rr_ptr <= next_idx(grant);
            else begin
               state     <= PASS;
               remaining <= len;
            end
         end else if (fire) begin
            remaining <= remaining - 1'b1;
            if (remaining == LOG_MAX_PACKET_LENGTH'(1)) begin
               state  <= IDLE;
               rr_ptr <= next_idx(cur_stream);
            end
         end
      end
   end
endmodule

// File: tb/tb_message_packet_arbiter.sv
// tb_message_packet_arbiter: randomized bench against a transaction-level reference model
module tb_message_packet_arbiter;
   localparam int N = 4, LN = 2, W = 32, LL = 10;

   logic           clk = 1'b0;
   logic           rst;
   logic [W*N-1:0] in_data;
   logic [N-1:0]   in_valid, in_ready;
   logic [W-1:0]   out_data;
   logic           out_valid, out_ready;
   logic [LN-1:0]  cur_stream;
   logic           busy, error;

   message_packet_arbiter #(
      .N_STREAMS(N), .LOG_N_STREAMS(LN), .WIDTH(W), .LOG_MAX_PACKET_LENGTH(LL)
   ) dut (
      .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .cur_stream(cur_stream), .busy(busy), .error(error)
   );

   always #5 clk = ~clk;

   int n_tests = 0, n_fail = 0;
   logic [W-1:0] q[N][$];

   // Reference model: owner (-1 = none), body words left, round-robin pointer
   int           owner, rem, ptr, m_cur;
   bit           m_err, m_ov;
   logic [W-1:0] m_od;

   task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      owner = -1; rem = 0; ptr = 0; m_cur = 0; m_err = 0; m_ov = 0; m_od = '0;
      for (int j = 0; j < N; j++) q[j].delete();
   endtask

   task automatic add_pkt(input int j, input int len);
      logic [W-1:0] h;
      h = $urandom;
      h[W-1] = 1'b1;
      h[W-2 -: LL] = LL'(len);
      q[j].push_back(h);
      for (int k = 0; k < len; k++) q[j].push_back($urandom);
   endtask

   task automatic add_junk(input int j, input logic [W-1:0] v);
      q[j].push_back(v & 32'h7fff_ffff);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      in_valid = '0;
      #1;
      check("rst_out_valid", W'(out_valid), 0);
      check("rst_busy", W'(busy), 0);
      check("rst_error", W'(error), 0);
      check("rst_in_ready", W'(in_ready), 0);
      check("rst_cur_stream", W'(cur_stream), 0);
      check("rst_out_data", out_data, 0);
      model_reset();
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic step(input int pv, input int pr);
      bit           can, fire;
      int           sel;
      logic [N-1:0] exp_rdy;
      logic [W-1:0] w;
      @(negedge clk);
      check("out_valid", W'(out_valid), W'(m_ov));
      if (m_ov) check("out_data", out_data, m_od);
      check("busy", W'(busy), W'(owner >= 0));
      check("error", W'(error), W'(m_err));
      check("cur_stream", W'(cur_stream), W'(m_cur));
      for (int j = 0; j < N; j++) begin
         in_valid[j] = q[j].size() > 0 && $urandom_range(99) < pv;
         in_data[j*W +: W] = in_valid[j] ? q[j][0] : $urandom;
      end
      out_ready = $urandom_range(99) < pr;
      #1;
      can = !m_ov || out_ready;
      sel = -1;
      if (can) begin
         if (owner >= 0) sel = owner;
         else for (int k = 0; k < N; k++)
            if (sel < 0 && in_valid[(ptr + k) % N]) sel = (ptr + k) % N;
      end
      exp_rdy = '0;
      if (sel >= 0) exp_rdy[sel] = 1'b1;
      check("in_ready", W'(in_ready), W'(exp_rdy));
      @(posedge clk);
      fire = sel >= 0 && in_valid[sel];
      if (can) m_ov = 0;
      if (fire) begin
         w = q[sel].pop_front();
         if (owner >= 0) begin
            m_od = w; m_ov = 1; rem--;
            if (rem == 0) begin
               ptr = (owner + 1) % N;
               owner = -1;
            end
         end else begin
            m_cur = sel;
            if (w[W-1]) begin
               m_od = w; m_ov = 1;
               rem = int'(w[W-2 -: LL]);
               if (rem == 0) ptr = (sel + 1) % N;
               else owner = sel;
            end else m_err = 1;
         end
      end
   endtask

   function automatic bit idle_all();
      bit e = owner < 0 && !m_ov;
      for (int j = 0; j < N; j++) e &= q[j].size() == 0;
      return e;
   endfunction

   task automatic drain(input int pv, input int pr);
      int budget = 20000;
      while (!idle_all() && budget > 0) begin
         step(pv, pr);
         budget--;
      end
      if (budget == 0) check("drain_timeout", 1, 0);
      repeat (2) step(pv, pr);
   endtask

   initial begin
      int budget;
      rst = 1'b1; in_valid = '0; out_ready = 1'b0; in_data = '0;
      model_reset();
      do_reset();
      add_pkt(0, 2);
      drain(100, 100);
      add_pkt(1, 1); add_pkt(2, 1);
      drain(100, 100);
      check("rr_ptr_after_pair", W'(ptr), 3);
      add_pkt(3, 0);
      drain(100, 100);
      check("rr_ptr_wrap", W'(ptr), 0);
      add_junk(0, 32'h0000_0005);
      drain(100, 100);
      check("error_sticky", W'(error), 1);
      add_pkt(0, 4);
      drain(100, 50);
      add_pkt(3, (1 << LL) - 1);
      drain(100, 100);
      add_pkt(1, 5);
      budget = 100;
      while (!(owner == 1 && rem == 3) && budget > 0) begin
         step(100, 100);
         budget--;
      end
      if (budget == 0) check("midpkt_timeout", 1, 0);
      do_reset();
      add_pkt(2, 1);
      drain(100, 100);
      for (int r = 0; r < 120; r++) begin
         if ($urandom_range(9) == 0) add_junk($urandom_range(N - 1), $urandom);
         else add_pkt($urandom_range(N - 1), $urandom_range(6));
      end
      drain(70, 60);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
